// File: rtl/gb_uart_loader_if.sv
// rtl/gb_uart_loader_if.sv - memory-controller UART load port bundle
interface gb_uart_loader_if;
   logic [27:0] uart_addr;
   logic [7:0]  uart_data_in;
   logic        uart_we;
   logic        uart_load;
   logic        load_ok;
   logic        load_err;

   modport master (
      output uart_addr, uart_data_in, uart_we, uart_load, load_ok, load_err
   );

   modport slave (
      input  uart_addr, uart_data_in, uart_we, uart_load, load_ok, load_err
   );
endinterface

// File: rtl/gb_uart_loader.sv
// rtl/gb_uart_loader.sv - 8N1 receiver and framed load-packet parser
// Drives ROM/BIOS/JBIOS image writes into the memory controller load port.
module gb_uart_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_CLKS = 2000000
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                rx_in,
   gb_uart_loader_if.master    bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_ADDR, P_LEN, P_DATA, P_CSUM} p_state_t;

   rx_state_t   rx_state_q;
   logic        rx_meta_q, rx_sync_q;
   logic [CW-1:0] bit_cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shreg_q;
   logic [7:0]  rx_byte_q;
   logic        byte_valid_q, frame_err_q;

   p_state_t    p_state_q;
   logic [1:0]  idx_q;
   logic [27:0] base_q;
   logic [23:0] len_q, wcnt_q;
   logic [7:0]  sum_q;
   logic [TW-1:0] tmo_q;
   logic [27:0] addr_q;
   logic [7:0]  data_q;
   logic        we_q, load_q, ok_q, err_q;

   logic [7:0]  sum_d;
   logic [23:0] len_d;
   logic [TW-1:0] tmo_d;

   assign sum_d = sum_q + rx_byte_q;
   assign len_d = {len_q[15:0], rx_byte_q};
   assign tmo_d = tmo_q + 1'b1;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_meta_q    <= rx_in;
         rx_sync_q    <= rx_meta_q;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               bit_cnt_q <= '0;
               bit_idx_q <= '0;
               if (!rx_sync_q) rx_state_q <= RX_START;
            end
            RX_START: begin
               // Re-sample mid start bit so later samples land mid-bit too.
               if (bit_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                  bit_cnt_q  <= '0;
                  rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  bit_cnt_q <= '0;
                  shreg_q   <= {rx_sync_q, shreg_q[7:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (bit_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                  bit_cnt_q  <= '0;
                  rx_state_q <= RX_IDLE;
                  if (rx_sync_q) begin
                     byte_valid_q <= 1'b1;
                     rx_byte_q    <= shreg_q;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         p_state_q <= P_IDLE;
         idx_q     <= '0;
         base_q    <= '0;
         len_q     <= '0;
         wcnt_q    <= '0;
         sum_q     <= '0;
         tmo_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         load_q    <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         we_q <= 1'b0;
         ok_q <= 1'b0;
         if (byte_valid_q) begin
            tmo_q <= '0;
            case (p_state_q)
               P_IDLE: if (rx_byte_q == 8'h55) begin
                  p_state_q <= P_ADDR;
                  idx_q     <= '0;
                  sum_q     <= '0;
                  load_q    <= 1'b1;
                  err_q     <= 1'b0;
               end
               P_ADDR: begin
                  sum_q  <= sum_d;
                  // The A3 high nibble falls off the top after four shifts.
                  base_q <= {base_q[19:0], rx_byte_q};
                  idx_q  <= idx_q + 1'b1;
                  if (idx_q == 2'd3) begin
                     p_state_q <= P_LEN;
                     idx_q     <= '0;
                  end
               end
               P_LEN: begin
                  sum_q <= sum_d;
                  len_q <= len_d;
                  idx_q <= idx_q + 1'b1;
                  if (idx_q == 2'd2) begin
                     idx_q     <= '0;
                     wcnt_q    <= '0;
                     p_state_q <= (len_d != 24'd0) ? P_DATA : P_CSUM;
                  end
               end
               P_DATA: begin
                  sum_q  <= sum_d;
                  data_q <= rx_byte_q;
                  addr_q <= base_q + {4'd0, wcnt_q};
                  we_q   <= 1'b1;
                  wcnt_q <= wcnt_q + 1'b1;
                  if (wcnt_q + 24'd1 == len_q) p_state_q <= P_CSUM;
               end
               P_CSUM: begin
                  if (sum_d == 8'h00) ok_q <= 1'b1;
                  else                err_q <= 1'b1;
                  load_q    <= 1'b0;
                  p_state_q <= P_IDLE;
               end
               default: p_state_q <= P_IDLE;
            endcase
         end else if (frame_err_q) begin
            err_q     <= 1'b1;
            load_q    <= 1'b0;
            tmo_q     <= '0;
            p_state_q <= P_IDLE;
         end else if (p_state_q != P_IDLE) begin
            if (tmo_d == TW'(TIMEOUT_CLKS)) begin
               err_q     <= 1'b1;
               load_q    <= 1'b0;
               tmo_q     <= '0;
               p_state_q <= P_IDLE;
            end else begin
               tmo_q <= tmo_d;
            end
         end else begin
            tmo_q <= '0;
         end
      end
   end

   assign bus.uart_addr    = addr_q;
   assign bus.uart_data_in = data_q;
   assign bus.uart_we      = we_q;
   assign bus.uart_load    = load_q;
   assign bus.load_ok      = ok_q;
   assign bus.load_err     = err_q;
endmodule

// File: tb/tb_gb_uart_loader.sv
// tb/tb_gb_uart_loader.sv - directed bench for gb_uart_loader
module tb_gb_uart_loader;
   localparam int CPB = 8;
   localparam int TMO = 400;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic rx_in = 1'b1;

   gb_uart_loader_if bus ();

   gb_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
      .clock (clock),
      .rst   (rst),
      .rx_in (rx_in),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   logic [27:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int ok_cnt  = 0;
   int bad_we  = 0;

   always @(negedge clock) begin
      if (!rst) begin
         if (bus.uart_we) begin
            wr_addr.push_back(bus.uart_addr);
            wr_data.push_back(bus.uart_data_in);
            if (!bus.uart_load) bad_we++;
         end
         if (bus.load_ok) ok_cnt++;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [7:0] tx_q[$];

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx_in = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx_in = stop;
      repeat (CPB) @(negedge clock);
      rx_in = 1'b1;
   endtask

   task automatic send_q();
      foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   int w0, k0;

   initial begin
      repeat (3) @(negedge clock);
      chk_eq("rst_addr", {4'd0, bus.uart_addr}, 32'h0);
      chk_eq("rst_data", {24'd0, bus.uart_data_in}, 32'h0);
      chk_eq("rst_ctrl", {28'd0, bus.uart_we, bus.uart_load, bus.load_ok, bus.load_err}, 32'h0);
      rst = 1'b0;
      idle(10);

      // case 1: two writes at 0x100
      w0 = wr_addr.size(); k0 = ok_cnt;
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB};
      send_q();
      chk_eq("c1_load_mid", {31'd0, bus.uart_load}, 32'h1);
      send_byte(8'h98, 1'b1);
      idle(4);
      chk_eq("c1_nwr", wr_addr.size() - w0, 2);
      chk_eq("c1_a0", {4'd0, wr_addr[w0]}, 32'h100);
      chk_eq("c1_d0", {24'd0, wr_data[w0]}, 32'hAA);
      chk_eq("c1_a1", {4'd0, wr_addr[w0+1]}, 32'h101);
      chk_eq("c1_d1", {24'd0, wr_data[w0+1]}, 32'hBB);
      chk_eq("c1_ok", ok_cnt - k0, 1);
      chk_eq("c1_err", {31'd0, bus.load_err}, 32'h0);
      chk_eq("c1_load_end", {31'd0, bus.uart_load}, 32'h0);

      // case 2: BIOS region single write
      w0 = wr_addr.size(); k0 = ok_cnt;
      tx_q = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h31, 8'hCD};
      send_q(); idle(4);
      chk_eq("c2_nwr", wr_addr.size() - w0, 1);
      chk_eq("c2_a0", {4'd0, wr_addr[w0]}, 32'h1000000);
      chk_eq("c2_d0", {24'd0, wr_data[w0]}, 32'h31);
      chk_eq("c2_ok", ok_cnt - k0, 1);

      // case 3: bad checksum, then sync clears the error
      w0 = wr_addr.size(); k0 = ok_cnt;
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h99};
      send_q(); idle(4);
      chk_eq("c3_nwr", wr_addr.size() - w0, 2);
      chk_eq("c3_ok", ok_cnt - k0, 0);
      chk_eq("c3_err", {31'd0, bus.load_err}, 32'h1);
      chk_eq("c3_load", {31'd0, bus.uart_load}, 32'h0);
      send_byte(8'h55, 1'b1); idle(4);
      chk_eq("c3_err_clr", {31'd0, bus.load_err}, 32'h0);
      chk_eq("c3_load_set", {31'd0, bus.uart_load}, 32'h1);
      tx_q = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF0};
      send_q(); idle(4);
      chk_eq("c3_len0_ok", ok_cnt - k0, 1);

      // case 4: framing error on first data byte
      w0 = wr_addr.size(); k0 = ok_cnt;
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
      send_q();
      send_byte(8'hAA, 1'b0);
      idle(20 * CPB);
      chk_eq("c4_nwr", wr_addr.size() - w0, 0);
      chk_eq("c4_err", {31'd0, bus.load_err}, 32'h1);
      chk_eq("c4_load", {31'd0, bus.uart_load}, 32'h0);
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h98};
      send_q(); idle(4);
      chk_eq("c4_next_nwr", wr_addr.size() - w0, 2);
      chk_eq("c4_next_ok", ok_cnt - k0, 1);
      chk_eq("c4_next_err", {31'd0, bus.load_err}, 32'h0);

      // case 5: start-bit glitch in idle, then mid-frame timeout
      w0 = wr_addr.size();
      rx_in = 1'b0; idle(3); rx_in = 1'b1;
      idle(200);
      chk_eq("c5_glitch_wr", wr_addr.size() - w0, 0);
      chk_eq("c5_glitch_st", {30'd0, bus.uart_load, bus.load_err}, 32'h0);
      tx_q = '{8'h55, 8'h00, 8'h00};
      send_q();
      idle(300);
      chk_eq("c5_pre_tmo", {30'd0, bus.uart_load, bus.load_err}, 32'h2);
      idle(150);
      chk_eq("c5_tmo_err", {31'd0, bus.load_err}, 32'h1);
      chk_eq("c5_tmo_load", {31'd0, bus.uart_load}, 32'h0);

      // case 6: reset mid-data, then recovery and zero-length frame
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA};
      send_q(); idle(2);
      chk_eq("c6_pre_addr", {4'd0, bus.uart_addr}, 32'h100);
      rst = 1'b1; #1;
      chk_eq("c6_rst_addr", {4'd0, bus.uart_addr}, 32'h0);
      chk_eq("c6_rst_data", {24'd0, bus.uart_data_in}, 32'h0);
      chk_eq("c6_rst_ctrl", {28'd0, bus.uart_we, bus.uart_load, bus.load_ok, bus.load_err}, 32'h0);
      idle(3); rst = 1'b0; idle(10);
      w0 = wr_addr.size(); k0 = ok_cnt;
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h98};
      send_q(); idle(4);
      chk_eq("c6_nwr", wr_addr.size() - w0, 2);
      chk_eq("c6_a1", {4'd0, wr_addr[w0+1]}, 32'h101);
      chk_eq("c6_ok", ok_cnt - k0, 1);
      w0 = wr_addr.size(); k0 = ok_cnt;
      tx_q = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hF0};
      send_q(); idle(4);
      chk_eq("len0_nwr", wr_addr.size() - w0, 0);
      chk_eq("len0_ok", ok_cnt - k0, 1);
      chk_eq("len0_err", {31'd0, bus.load_err}, 32'h0);

      chk_eq("we_without_load", bad_we, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
